// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, optional even parity,
// one-cycle strobes for a good byte, a parity mismatch or a framing error.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 rx_m;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      shreg      <= '0;
      par_err    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          par_err <= 1'b0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_err <= (^shreg) ^ rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              parity_err <= par_err;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
